// File: rtl/eth_phy_10g_rx_link_ctrl_pkg.sv
// Shared types and widths for the 10GBASE-R RX link controller.
// Link state encodings and statistics counter widths.
package eth_phy_10g_rx_link_ctrl_pkg;

  typedef enum logic [1:0] {
    LINK_RESET_SERDES = 2'd0,
    LINK_WAIT_LOCK    = 2'd1,
    LINK_QUALIFY      = 2'd2,
    LINK_UP           = 2'd3
  } link_state_e;

  localparam int STAT16_W = 16;
  localparam int STAT32_W = 32;
  localparam int ERR_IN_W = 7;

endpackage

// File: rtl/eth_phy_10g_rx_link_ctrl_if.sv
// Status, control and statistics bundle of the RX link controller.
// The slave side is the controller; the master side is PHY/MAC/mgmt.
interface eth_phy_10g_rx_link_ctrl_if;
  import eth_phy_10g_rx_link_ctrl_pkg::*;

  logic                rx_block_lock;
  logic                rx_high_ber;
  logic [ERR_IN_W-1:0] rx_error_count;
  logic                rx_bad_block;
  logic                clear_stats;
  logic                serdes_rx_reset_req;
  logic                mac_rx_rst;
  logic                link_up;
  logic [1:0]          link_state;
  logic [STAT16_W-1:0] link_down_count;
  logic [STAT32_W-1:0] error_total;
  logic [STAT16_W-1:0] bad_block_total;

  modport master (
    output rx_block_lock,
    output rx_high_ber,
    output rx_error_count,
    output rx_bad_block,
    output clear_stats,
    input  serdes_rx_reset_req,
    input  mac_rx_rst,
    input  link_up,
    input  link_state,
    input  link_down_count,
    input  error_total,
    input  bad_block_total
  );

  modport slave (
    input  rx_block_lock,
    input  rx_high_ber,
    input  rx_error_count,
    input  rx_bad_block,
    input  clear_stats,
    output serdes_rx_reset_req,
    output mac_rx_rst,
    output link_up,
    output link_state,
    output link_down_count,
    output error_total,
    output bad_block_total
  );

endinterface

// File: rtl/eth_phy_10g_rx_link_ctrl_sat_counter.sv
// Saturating accumulator with a synchronous clear that beats
// any same-cycle increment.
module eth_sat_counter #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, count}
             + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc};

  // Accumulate, clamping to all-ones on carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10GBASE-R RX link bring-up: SERDES reset sequencing, lock
// qualification, link supervision and saturating statistics.
module eth_phy_10g_rx_link_ctrl
  import eth_phy_10g_rx_link_ctrl_pkg::*;
#(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int QUALIFY_CYCLES      = 19531,
  parameter int CNT_WIDTH           = 32
) (
  input logic                       clk,
  input logic                       rst,
  eth_phy_10g_rx_link_ctrl_if.slave link
);

  localparam logic [CNT_WIDTH-1:0] PULSE_LAST =
    CNT_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST =
    CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] QUAL_LAST =
    CNT_WIDTH'(QUALIFY_CYCLES - 1);

  link_state_e          state;
  link_state_e          nxt;
  logic [CNT_WIDTH-1:0] timer;
  logic                 good;
  logic                 down_evt;
  logic                 bad_evt;

  assign good = link.rx_block_lock && !link.rx_high_ber;

  // Next-state rules; lock beats the timeout in WAIT_LOCK.
  always_comb begin
    nxt = state;
    unique case (state)
      LINK_RESET_SERDES: begin
        if (timer == PULSE_LAST) nxt = LINK_WAIT_LOCK;
      end
      LINK_WAIT_LOCK: begin
        if (good) nxt = LINK_QUALIFY;
        else if (timer == LOCK_LAST) nxt = LINK_RESET_SERDES;
      end
      LINK_QUALIFY: begin
        if (!good) nxt = LINK_WAIT_LOCK;
        else if (timer == QUAL_LAST) nxt = LINK_UP;
      end
      LINK_UP: begin
        if (!good) nxt = LINK_WAIT_LOCK;
      end
      default: nxt = LINK_RESET_SERDES;
    endcase
  end

  // State, timer and outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= LINK_RESET_SERDES;
      timer                    <= '0;
      link.serdes_rx_reset_req <= 1'b1;
      link.mac_rx_rst          <= 1'b1;
      link.link_up             <= 1'b0;
      link.link_state          <= LINK_RESET_SERDES;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 1'b1;
      end
      link.serdes_rx_reset_req <= (nxt == LINK_RESET_SERDES);
      link.mac_rx_rst          <= (nxt != LINK_UP);
      link.link_up             <= (nxt == LINK_UP);
      link.link_state          <= nxt;
    end
  end

  assign down_evt = (state == LINK_UP) && (nxt != LINK_UP);
  assign bad_evt  = (state == LINK_UP) && link.rx_bad_block;

  eth_sat_counter #(
    .WIDTH     (STAT16_W),
    .INC_WIDTH (1)
  ) u_down_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (link.clear_stats),
    .inc   (down_evt),
    .count (link.link_down_count)
  );

  eth_sat_counter #(
    .WIDTH     (STAT32_W),
    .INC_WIDTH (ERR_IN_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (link.clear_stats),
    .inc   (link.rx_error_count),
    .count (link.error_total)
  );

  eth_sat_counter #(
    .WIDTH     (STAT16_W),
    .INC_WIDTH (1)
  ) u_bad_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (link.clear_stats),
    .inc   (bad_evt),
    .count (link.bad_block_total)
  );

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Bench for the RX link controller: directed bring-up scenarios
// plus random traffic against a cycle-level behavioural model.
module tb_eth_phy_10g_rx_link_ctrl;
  import eth_phy_10g_rx_link_ctrl_pkg::*;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int QC = 10;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX16 = 64'hFFFF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  eth_phy_10g_rx_link_ctrl_if bus ();

  eth_phy_10g_rx_link_ctrl #(
    .RESET_PULSE_CYCLES  (RP),
    .LOCK_TIMEOUT_CYCLES (LT),
    .QUALIFY_CYCLES      (QC),
    .CNT_WIDTH           (32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  logic       sc_clr;
  logic [6:0] sc_inc;
  logic [7:0] sc_count;

  eth_sat_counter #(
    .WIDTH     (8),
    .INC_WIDTH (7)
  ) u_sc (
    .clk   (clk),
    .rst   (rst),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc_count)
  );

  int errors = 0;
  int checks = 0;

  int     m_state;
  int     m_timer;
  longint m_down;
  longint m_err;
  longint m_bad;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_timer = 0;
    m_down  = 0;
    m_err   = 0;
    m_bad   = 0;
  endtask

  task automatic check_all();
    check("link_state", longint'(bus.link_state), m_state);
    check("serdes_req", longint'(bus.serdes_rx_reset_req),
          longint'(m_state == 0));
    check("mac_rx_rst", longint'(bus.mac_rx_rst),
          longint'(m_state != 3));
    check("link_up", longint'(bus.link_up), longint'(m_state == 3));
    check("down_cnt", longint'(bus.link_down_count), m_down);
    check("err_total", longint'(bus.error_total), m_err);
    check("bad_total", longint'(bus.bad_block_total), m_bad);
  endtask

  // One clock: drive, let the edge happen, advance model, compare.
  task automatic step(bit lock, bit ber, int ec, bit bad, bit clr);
    int nxt;
    bit good;
    bus.rx_block_lock  = lock;
    bus.rx_high_ber    = ber;
    bus.rx_error_count = 7'(ec);
    bus.rx_bad_block   = bad;
    bus.clear_stats    = clr;
    @(posedge clk);
    good = lock && !ber;
    nxt  = m_state;
    case (m_state)
      0: if (m_timer == RP - 1) nxt = 1;
      1: if (good) nxt = 2; else if (m_timer == LT - 1) nxt = 0;
      2: if (!good) nxt = 1; else if (m_timer == QC - 1) nxt = 3;
      default: if (!good) nxt = 1;
    endcase
    if (clr) begin
      m_err  = 0;
      m_bad  = 0;
      m_down = 0;
    end else begin
      m_err = m_err + ec;
      if (m_err > MAX32) m_err = MAX32;
      if (bad && m_state == 3 && m_bad < MAX16) m_bad++;
      if (m_state == 3 && nxt != 3 && m_down < MAX16) m_down++;
    end
    m_timer = (nxt == m_state) ? m_timer + 1 : 0;
    m_state = nxt;
    #1;
    check_all();
  endtask

  task automatic rnd_step(bit lock, bit ber);
    step(lock, ber, int'($urandom_range(0, 127)),
         1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic go_up();
    int n = 0;
    while (m_state != 3 && n < 100) begin
      rnd_step(1'b1, 1'b0);
      n++;
    end
    check("reach_up", longint'(m_state), 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.rx_block_lock  = 1'b0;
    bus.rx_high_ber    = 1'b0;
    bus.rx_error_count = '0;
    bus.rx_bad_block   = 1'b0;
    bus.clear_stats    = 1'b0;
    sc_clr = 1'b0;
    sc_inc = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // No lock: reset pulses of RP cycles separated by LT cycles.
    for (int i = 0; i < 2 * (RP + LT) + 3; i++)
      rnd_step(1'b0, 1'b0);

    // Lock 3 cycles into WAIT_LOCK, then qualify to UP.
    n = 0;
    while (m_state != 1 && n < 50) begin
      rnd_step(1'b0, 1'b0);
      n++;
    end
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b0);
    rnd_step(1'b1, 1'b0);
    check("qual_entry", longint'(bus.link_state), 2);
    for (int i = 0; i < QC - 1; i++) rnd_step(1'b1, 1'b0);
    check("qual_not_yet", longint'(bus.link_up), 0);
    rnd_step(1'b1, 1'b0);
    check("up_after_qc", longint'(bus.link_up), 1);
    check("up_mac_rst", longint'(bus.mac_rx_rst), 0);
    check("up_downs0", longint'(bus.link_down_count), 0);

    // High BER for one cycle while UP.
    rnd_step(1'b1, 1'b1);
    check("ber_state", longint'(bus.link_state), 1);
    check("ber_up", longint'(bus.link_up), 0);
    check("ber_downs", longint'(bus.link_down_count), 1);
    check("ber_serdes", longint'(bus.serdes_rx_reset_req), 0);

    // One-cycle lock drop at QUALIFY timer 7 restarts qualification.
    n = 0;
    while (!(m_state == 2 && m_timer == 7) && n < 50) begin
      rnd_step(1'b1, 1'b0);
      n++;
    end
    rnd_step(1'b0, 1'b0);
    check("glitch_state", longint'(bus.link_state), 1);
    for (int i = 0; i < QC; i++) rnd_step(1'b1, 1'b0);
    check("glitch_not_up", longint'(bus.link_up), 0);
    rnd_step(1'b1, 1'b0);
    check("glitch_up", longint'(bus.link_up), 1);

    // Random traffic with occasional lock loss, BER and clears.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 40) == 0),
           int'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 60) == 0));
    end

    // Clear beats a same-cycle bad block in UP.
    go_up();
    step(1'b1, 1'b0, 5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 5, 1'b1, 1'b1);
    check("clr_bad", longint'(bus.bad_block_total), 0);
    check("clr_err", longint'(bus.error_total), 0);

    // Asynchronous reset in the middle of UP.
    go_up();
    step(1'b1, 1'b0, 9, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst_state", longint'(bus.link_state), 0);
    check("arst_serdes", longint'(bus.serdes_rx_reset_req), 1);
    check("arst_up", longint'(bus.link_up), 0);
    check("arst_mac", longint'(bus.mac_rx_rst), 1);
    check("arst_err", longint'(bus.error_total), 0);
    check("arst_bad", longint'(bus.bad_block_total), 0);
    check("arst_down", longint'(bus.link_down_count), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) rnd_step(1'b1, 1'b0);

    // Saturation and clear priority on a narrow counter.
    sc_clr = 1'b1;
    @(posedge clk);
    #1 sc_clr = 1'b0;
    check("sc_clear", longint'(sc_count), 0);
    sc_inc = 7'd127;
    @(posedge clk);
    #1 check("sc_127", longint'(sc_count), 127);
    @(posedge clk);
    #1 check("sc_254", longint'(sc_count), 254);
    @(posedge clk);
    #1 check("sc_sat", longint'(sc_count), 255);
    @(posedge clk);
    #1 check("sc_hold", longint'(sc_count), 255);
    sc_clr = 1'b1;
    @(posedge clk);
    #1 check("sc_clr_win", longint'(sc_count), 0);
    sc_clr = 1'b0;
    sc_inc = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_rx_link_ctrl.md
Name: eth_phy_10g_rx_link_ctrl

Overview:
Link bring-up and supervision controller for the 10GBASE-R receive path (PHY RX interface plus 64-bit BASE-R MAC RX).
- Watches block lock, high-BER and per-cycle error outputs.
- Sequences SERDES RX resets when lock is not acquired, qualifies a stable link before releasing the MAC RX from reset, and drops the link on lock loss or high BER.
- Keeps saturating link statistics for the management layer.

Parameters:
RESET_PULSE_CYCLES, 16, cycles serdes_rx_reset_req is held per reset attempt (>=1)
LOCK_TIMEOUT_CYCLES, 1000000, cycles in WAIT_LOCK without lock before a new SERDES reset (>=1)
QUALIFY_CYCLES, 19531, cycles of continuous lock && !high_ber before link up (~125 us at 6.4 ns) (>=1)
CNT_WIDTH, 32, width of the cycle timer; must hold max(LOCK_TIMEOUT_CYCLES, QUALIFY_CYCLES, RESET_PULSE_CYCLES)

Ports:
clk  in  1  RX PHY clock; all logic in this domain
rst  in  1  asynchronous, active-high reset
rx_block_lock  in  1  block lock from PHY RX
rx_high_ber  in  1  high BER from PHY RX
rx_error_count  in  7  sync-header errors this cycle from PHY RX
rx_bad_block  in  1  bad-block strobe from MAC RX
clear_stats  in  1  synchronous clear of statistics counters
serdes_rx_reset_req  out  1  SERDES RX datapath reset request
mac_rx_rst  out  1  reset to MAC RX path; high whenever link is not up
link_up  out  1  link qualified and up
link_state  out  2  0=RESET_SERDES 1=WAIT_LOCK 2=QUALIFY 3=UP
link_down_count  out  16  UP->down transitions, saturating
error_total  out  32  accumulated rx_error_count, saturating
bad_block_total  out  16  rx_bad_block strobes counted while UP, saturating

Behaviour:
- Reset (async assert, release on the next clk edge):
  - State RESET_SERDES, timer 0.
  - serdes_rx_reset_req=1, mac_rx_rst=1, link_up=0; all counters 0.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as its state.
- Timer: cleared on every state change, otherwise increments, saturating at its maximum.
- RESET_SERDES:
  - serdes_rx_reset_req=1.
  - When timer==RESET_PULSE_CYCLES-1 -> WAIT_LOCK. The pulse is exactly RESET_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - serdes_rx_reset_req=0.
  - If rx_block_lock && !rx_high_ber -> QUALIFY.
  - Else if timer==LOCK_TIMEOUT_CYCLES-1 -> RESET_SERDES.
  - Lock wins if both conditions hold in the same cycle.
- QUALIFY:
  - If !rx_block_lock || rx_high_ber -> WAIT_LOCK (no SERDES reset).
  - Else if timer==QUALIFY_CYCLES-1 -> UP.
- UP:
  - link_up=1, mac_rx_rst=0.
  - If !rx_block_lock || rx_high_ber -> WAIT_LOCK and link_down_count += 1.
  - On that same edge mac_rx_rst=1 and link_up=0.
- mac_rx_rst = (state != UP); link_up = (state == UP); serdes_rx_reset_req = (state == RESET_SERDES).
- error_total:
  - Adds zero-extended rx_error_count every cycle in any state, saturating at 2^32-1.
  - If the sum overflows, the result clamps to all-ones.
- bad_block_total: +1 per cycle with rx_bad_block && state==UP, saturating at 0xFFFF.
- link_down_count saturates at 0xFFFF.
- clear_stats: zeroes all three counters on the next edge. Clear wins over a same-cycle increment; that cycle's increment is discarded. The state machine is unaffected.
- Input glitches shorter than one cycle are not filtered beyond sampling on clk. Any single low cycle of lock in QUALIFY restarts qualification.

Decomposition:
- Shared package/header holds:
  - link state encodings (LINK_RESET_SERDES=0, LINK_WAIT_LOCK=1, LINK_QUALIFY=2, LINK_UP=3);
  - statistics widths (16/32).
- One sub-module is natural: eth_sat_counter (parameterised width and increment width, saturating add, synchronous clear with priority). It is instantiated three times.
- FSM and timer stay in the top module.

Test Plan:
(All with RESET_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, QUALIFY_CYCLES=10.)
- Reset, lock tied 0 -> serdes_rx_reset_req high 4 cycles, low 20 cycles, repeating; link_state alternates 0/1; mac_rx_rst stays 1.
- Lock asserted 3 cycles after entering WAIT_LOCK, held -> QUALIFY, then link_up=1 and mac_rx_rst=0 exactly 10 cycles later; link_down_count=0.
- In QUALIFY, drop lock for 1 cycle at timer=7 -> returns to WAIT_LOCK. Qualification restarts, so UP is reached only after 10 further clean cycles.
- In UP, assert rx_high_ber 1 cycle -> next edge link_state=1, link_up=0, mac_rx_rst=1, link_down_count=1; no serdes_rx_reset_req pulse.
- Drive rx_error_count=127 with error_total preloaded near max via long run -> saturates at 0xFFFFFFFF. clear_stats with a same-cycle rx_bad_block in UP -> bad_block_total=0 next cycle.
- Assert rst mid-UP -> outputs immediately (asynchronously) return to reset values: link_state=0, serdes_rx_reset_req=1, counters 0.
